serial_async_rx_fifo: RTL and testbench

Parametrised asynchronous serial receiver that runs directly on the oversampled serial clock. It improves on the single-sample receiver in four ways: 3-sample majority voting per bit, start-glitch rejection, configurable even/odd parity checking, and frame-error recovery without lock-up. Received words, each with its error flags, go into a small show-ahead FIFO that downstream logic reads with a valid/ready handshake. The block sits between the UART pin synchroniser domain and the protocol/command logic.

---
 rtl/serial_async_rx_fifo_pkg.sv | 23 ++
 rtl/serial_async_rx_fifo_if.sv | 22 ++
 rtl/serial_async_rx_fifo_fifo.sv | 52 +++++
 rtl/serial_async_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_serial_async_rx_fifo.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_async_rx_fifo_pkg.sv
// Shared types and helpers for the oversampled serial receiver and its output FIFO.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } t_parity;

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
    Parity,
    Stop,
    WaitIdle
  } t_rx_state;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/serial_async_rx_fifo_if.sv
// Received-word stream: show-ahead head word with its error flags, consumer ready.
interface serial_async_rx_fifo_if #(
  parameter int unsigned BITS = 8
) ();

  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_parity_err;
  logic            out_frame_err;
  logic            in_ready;

  modport master (
    output out_data, out_valid, out_parity_err, out_frame_err,
    input  in_ready
  );

  modport slave (
    input  out_data, out_valid, out_parity_err, out_frame_err,
    output in_ready
  );

endinterface

// File: rtl/serial_async_rx_fifo_fifo.sv
// Small show-ahead FIFO; pointers carry a wrap bit so full and empty are unambiguous.
module fifo_sync_showahead #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             serial_clk,
  input  logic             in_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic             pop_ok
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;

  // NOTE: every output is given a value on every path, so no latch is inferred.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok    = pop && !empty;
    push_ok   = push && (!full || pop_ok);
    wr_ptr_d  = wr_ptr_q + PW'(push_ok);
    rd_ptr_d  = rd_ptr_q + PW'(pop_ok);
    head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge serial_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the head output is forced to zero while empty instead.
  always_ff @(posedge serial_clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/serial_async_rx_fifo.sv
// Oversampled serial receiver with 3-sample majority voting, parity and framing
// checks, feeding a show-ahead FIFO read over a valid/ready handshake.
module serial_async_rx_fifo
  import serial_rx_pkg::*;
#(
  parameter int unsigned CLK_MULTIPLE = 8,
  parameter int unsigned BITS         = 8,
  parameter t_parity     PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter bit          LOWBIT_FIRST = 1'b1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   serial_clk,
  input  logic                   in_rst,
  input  logic                   in_enable,
  input  logic                   in_serial,
  input  logic                   in_clear_err,
  serial_async_rx_fifo_if.master rx_if,
  output logic                   out_overflow,
  output logic                   out_idle
);

  localparam int unsigned H     = CLK_MULTIPLE / 2;
  localparam int unsigned SC_W  = $clog2(CLK_MULTIPLE);
  localparam int unsigned BC_W  = $clog2(BITS) + 1;
  localparam int unsigned IDX_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned WIDTH = BITS + 2;

  t_rx_state       state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            rx_s_q, rx_s_d;
  logic            rx_prev_q, rx_prev_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [BC_W-1:0] bit_ctr_q, bit_ctr_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [1:0]      samp_q, samp_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;

  logic             sc_wrap, decide, maj, fall, push;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] head_data;
  logic             fifo_empty, fifo_full, fifo_pop_ok;

  assign sc_wrap = (sc_q == SC_W'(CLK_MULTIPLE - 1));
  assign decide  = (sc_q == SC_W'(H + 1));
  assign maj     = maj3({rx_s_q, samp_q});
  assign fall    = rx_prev_q && !rx_s_q;
  assign bit_idx = LOWBIT_FIRST ? bit_ctr_q[IDX_W-1:0]
                                : IDX_W'(BITS - 1) - bit_ctr_q[IDX_W-1:0];

  always_comb begin
    sync1_d      = in_serial;
    rx_s_d       = sync1_q;
    rx_prev_d    = rx_s_q;
    state_d      = state_q;
    sc_d         = sc_wrap ? '0 : sc_q + 1'b1;
    bit_ctr_d    = bit_ctr_q;
    shift_d      = shift_q;
    samp_d       = samp_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    push         = 1'b0;

    if (sc_q == SC_W'(H - 1)) samp_d[0] = rx_s_q;
    if (sc_q == SC_W'(H))     samp_d[1] = rx_s_q;

    unique case (state_q)
      Idle: begin
        sc_d      = '0;
        bit_ctr_d = '0;
        // The edge cycle itself is sample 0 of the start bit.
        if (fall && in_enable) begin
          state_d      = Start;
          sc_d         = SC_W'(1);
          shift_d      = '0;
          parity_err_d = 1'b0;
          frame_err_d  = 1'b0;
        end
      end
      Start: begin
        if (decide && maj) begin
          state_d = Idle;
          sc_d    = '0;
        end else if (sc_wrap) begin
          state_d = Data;
        end
      end
      Data: begin
        if (decide) shift_d[bit_idx] = maj;
        if (sc_wrap) begin
          if (bit_ctr_q == BC_W'(BITS - 1)) begin
            bit_ctr_d = '0;
            state_d   = (PARITY != PAR_NONE) ? Parity : Stop;
          end else begin
            bit_ctr_d = bit_ctr_q + 1'b1;
          end
        end
      end
      Parity: begin
        if (decide) parity_err_d = (PARITY == PAR_ODD) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
        if (sc_wrap) state_d = Stop;
      end
      Stop: begin
        if (decide) begin
          if (!maj) frame_err_d = 1'b1;
          // Good frames return to Idle mid-stop-bit so the next start edge is never missed.
          if (bit_ctr_q == BC_W'(STOP_BITS - 1)) begin
            push      = 1'b1;
            bit_ctr_d = '0;
            sc_d      = '0;
            state_d   = frame_err_d ? WaitIdle : Idle;
          end
        end
        if (sc_wrap && !push) bit_ctr_d = bit_ctr_q + 1'b1;
      end
      WaitIdle: begin
        if (!rx_s_q) begin
          sc_d = '0;
        end else if (sc_wrap) begin
          state_d = Idle;
          sc_d    = '0;
        end
      end
      default: begin
        state_d = Idle;
        sc_d    = '0;
      end
    endcase
  end

  // A full-FIFO push only survives if the consumer pops in the same cycle.
  always_comb begin
    overflow_d = overflow_q & ~in_clear_err;
    if (push && fifo_full && !fifo_pop_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge serial_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= Idle;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      sc_q         <= '0;
      bit_ctr_q    <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      sc_q         <= sc_d;
      bit_ctr_q    <= bit_ctr_d;
      shift_q      <= shift_d;
      samp_q       <= samp_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  fifo_sync_showahead #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .serial_clk (serial_clk),
    .in_rst     (in_rst),
    .push       (push),
    .push_data  ({frame_err_d, parity_err_q, shift_q}),
    .pop        (rx_if.in_ready),
    .head_data  (head_data),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .pop_ok     (fifo_pop_ok)
  );

  assign rx_if.out_data       = head_data[BITS-1:0];
  assign rx_if.out_parity_err = head_data[BITS];
  assign rx_if.out_frame_err  = head_data[BITS+1];
  assign rx_if.out_valid      = !fifo_empty;
  assign out_overflow         = overflow_q;
  assign out_idle             = (state_q == Idle);

endmodule

// File: tb/tb_serial_async_rx_fifo.sv
// Directed bench: three receivers (even parity, odd parity, MSB-first no parity),
// one selected at a time onto a shared stimulus line.
module tb_serial_async_rx_fifo;
  import serial_rx_pkg::*;

  localparam int CM = 8;

  logic clk = 1'b0;
  logic rst, line, ready, clear_err, enable;
  int   sel;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  serial_async_rx_fifo_if #(.BITS(8)) if_even ();
  serial_async_rx_fifo_if #(.BITS(8)) if_odd  ();
  serial_async_rx_fifo_if #(.BITS(8)) if_msb  ();

  logic ser_even, ser_odd, ser_msb;
  logic ovf_even, ovf_odd, ovf_msb;
  logic idle_even, idle_odd, idle_msb;

  assign ser_even = (sel == 0) ? line : 1'b1;
  assign ser_odd  = (sel == 1) ? line : 1'b1;
  assign ser_msb  = (sel == 2) ? line : 1'b1;
  assign if_even.in_ready = ready && (sel == 0);
  assign if_odd.in_ready  = ready && (sel == 1);
  assign if_msb.in_ready  = ready && (sel == 2);

  serial_async_rx_fifo #(.CLK_MULTIPLE(CM), .BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1),
                         .LOWBIT_FIRST(1'b1), .FIFO_DEPTH(4)) dut_even (
    .serial_clk(clk), .in_rst(rst), .in_enable(enable), .in_serial(ser_even),
    .in_clear_err(clear_err), .rx_if(if_even), .out_overflow(ovf_even), .out_idle(idle_even));

  serial_async_rx_fifo #(.CLK_MULTIPLE(CM), .BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1),
                         .LOWBIT_FIRST(1'b1), .FIFO_DEPTH(4)) dut_odd (
    .serial_clk(clk), .in_rst(rst), .in_enable(enable), .in_serial(ser_odd),
    .in_clear_err(clear_err), .rx_if(if_odd), .out_overflow(ovf_odd), .out_idle(idle_odd));

  serial_async_rx_fifo #(.CLK_MULTIPLE(CM), .BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1),
                         .LOWBIT_FIRST(1'b0), .FIFO_DEPTH(4)) dut_msb (
    .serial_clk(clk), .in_rst(rst), .in_enable(enable), .in_serial(ser_msb),
    .in_clear_err(clear_err), .rx_if(if_msb), .out_overflow(ovf_msb), .out_idle(idle_msb));

  logic [7:0] cur_data;
  logic       cur_valid, cur_pe, cur_fe, cur_ovf, cur_idle;

  always_comb begin
    cur_data = if_even.out_data; cur_valid = if_even.out_valid;
    cur_pe   = if_even.out_parity_err; cur_fe = if_even.out_frame_err;
    cur_ovf  = ovf_even; cur_idle = idle_even;
    if (sel == 1) begin
      cur_data = if_odd.out_data; cur_valid = if_odd.out_valid;
      cur_pe   = if_odd.out_parity_err; cur_fe = if_odd.out_frame_err;
      cur_ovf  = ovf_odd; cur_idle = idle_odd;
    end else if (sel == 2) begin
      cur_data = if_msb.out_data; cur_valid = if_msb.out_valid;
      cur_pe   = if_msb.out_parity_err; cur_fe = if_msb.out_frame_err;
      cur_ovf  = ovf_msb; cur_idle = idle_msb;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    line = b;
    repeat (CM) tick();
  endtask

  task automatic send_head(input logic [7:0] d, input logic msb, input logic has_par,
                           input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(msb ? d[7-i] : d[i]);
    if (has_par) send_bit(par);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic msb, input logic has_par,
                            input logic par, input logic stop);
    send_head(d, msb, has_par, par);
    send_bit(stop);
    line = 1'b1;
    repeat (4) tick();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, ".valid"}, 32'(cur_valid), 32'd1);
    check({tag, ".data"},  32'(cur_data),  32'(d));
    check({tag, ".perr"},  32'(cur_pe),    32'(pe));
    check({tag, ".ferr"},  32'(cur_fe),    32'(fe));
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    logic [7:0] ovf_words [5];
    ovf_words[0] = 8'h11; ovf_words[1] = 8'h22; ovf_words[2] = 8'h33;
    ovf_words[3] = 8'h44; ovf_words[4] = 8'h55;

    rst = 1'b1; line = 1'b1; ready = 1'b0; clear_err = 1'b0; enable = 1'b1; sel = 0;
    repeat (3) tick();
    check("rst.data",  32'(cur_data),  32'h0);
    check("rst.valid", 32'(cur_valid), 32'h0);
    check("rst.perr",  32'(cur_pe),    32'h0);
    check("rst.ferr",  32'(cur_fe),    32'h0);
    check("rst.ovf",   32'(cur_ovf),   32'h0);
    check("rst.idle",  32'(cur_idle),  32'h1);
    rst = 1'b0;
    repeat (4) tick();

    // Even parity, 0xA5: push lands 5 samples into the stop bit after 2 sync stages.
    send_head(8'hA5, 1'b0, 1'b1, 1'b0);
    line = 1'b1;
    repeat (7) tick();
    check("a5.valid_early", 32'(cur_valid), 32'h0);
    tick();
    check("a5.valid_rise", 32'(cur_valid), 32'h1);
    repeat (4) tick();
    pop_check("a5", 8'hA5, 1'b0, 1'b0);

    // in_enable low: frame ignored.
    enable = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    check("dis.valid", 32'(cur_valid), 32'h0);
    check("dis.idle",  32'(cur_idle),  32'h1);
    enable = 1'b1;

    // Two-cycle start glitch rejected, then a clean 0x5A.
    line = 1'b0;
    repeat (2) tick();
    line = 1'b1;
    tick();
    check("glitch.in_start", 32'(cur_idle), 32'h0);
    repeat (4) tick();
    check("glitch.deciding", 32'(cur_idle), 32'h0);
    tick();
    check("glitch.idle", 32'(cur_idle), 32'h1);
    check("glitch.valid", 32'(cur_valid), 32'h0);
    repeat (4) tick();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    pop_check("5a", 8'h5A, 1'b0, 1'b0);
    check("5a.only_one", 32'(cur_valid), 32'h0);

    // Break: all zeros, stop low, line held low, then recovery.
    send_head(8'h00, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0);
    repeat (20) tick();
    line = 1'b1;
    repeat (9) tick();
    check("brk.waitidle", 32'(cur_idle), 32'h0);
    tick();
    check("brk.idle", 32'(cur_idle), 32'h1);
    pop_check("brk", 8'h00, 1'b0, 1'b1);
    repeat (4) tick();
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
    pop_check("81", 8'h81, 1'b0, 1'b0);

    // Odd parity receiver.
    sel = 1;
    repeat (4) tick();
    send_frame(8'h03, 1'b0, 1'b1, 1'b0, 1'b1);
    pop_check("odd_bad", 8'h03, 1'b1, 1'b0);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, 1'b1);
    pop_check("odd_ok", 8'h03, 1'b0, 1'b0);

    // Overflow: five words into a four-deep FIFO with no consumer.
    for (int i = 0; i < 5; i++)
      send_frame(ovf_words[i], 1'b0, 1'b1, ~(^ovf_words[i]), 1'b1);
    check("ovf.set", 32'(cur_ovf), 32'h1);
    for (int i = 0; i < 4; i++)
      pop_check($sformatf("ovf.w%0d", i), ovf_words[i], 1'b0, 1'b0);
    check("ovf.drained", 32'(cur_valid), 32'h0);
    check("ovf.sticky",  32'(cur_ovf),   32'h1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("ovf.cleared", 32'(cur_ovf), 32'h0);

    // MSB-first receiver, then reset during bit 4 of a second frame.
    sel = 2;
    repeat (4) tick();
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
    check("c3.valid", 32'(cur_valid), 32'h1);
    check("c3.data",  32'(cur_data),  32'hC3);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    line = 1'b1;
    repeat (3) tick();
    check("mid.busy", 32'(cur_idle), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.idle",  32'(cur_idle),  32'h1);
    check("mid.valid", 32'(cur_valid), 32'h0);
    repeat (100) tick();
    check("mid.no_partial", 32'(cur_valid), 32'h0);
    check("mid.still_idle", 32'(cur_idle),  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
